// File: rtl/opmux_pkg.sv
// Shared constants for the operation select mux: mode codes, bus widths and
// active-high hex segment patterns (bit0=a .. bit6=g).
package opmux_pkg;

    localparam int RESULT_W = 5;
    localparam int SEG_W    = 7;

    localparam logic [1:0] MODE_PIPO = 2'b00;
    localparam logic [1:0] MODE_ALU  = 2'b01;
    localparam logic [1:0] MODE_MOD5 = 2'b10;
    localparam logic [1:0] MODE_SSD  = 2'b11;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    // Patterns written gfedcba, so the MSB is segment g.
    localparam logic [SEG_W-1:0] SEG_HEX_0 = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_HEX_1 = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_HEX_2 = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_HEX_3 = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_HEX_4 = 7'b1100110;
    localparam logic [SEG_W-1:0] SEG_HEX_5 = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_HEX_6 = 7'b1111101;
    localparam logic [SEG_W-1:0] SEG_HEX_7 = 7'b0000111;
    localparam logic [SEG_W-1:0] SEG_HEX_8 = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_HEX_9 = 7'b1101111;
    localparam logic [SEG_W-1:0] SEG_HEX_A = 7'b1110111;
    localparam logic [SEG_W-1:0] SEG_HEX_B = 7'b1111100;
    localparam logic [SEG_W-1:0] SEG_HEX_C = 7'b0111001;
    localparam logic [SEG_W-1:0] SEG_HEX_D = 7'b1011110;
    localparam logic [SEG_W-1:0] SEG_HEX_E = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_HEX_F = 7'b1110001;

    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] digit);
        logic [SEG_W-1:0] seg;
        case (digit)
            4'h0:    seg = SEG_HEX_0;
            4'h1:    seg = SEG_HEX_1;
            4'h2:    seg = SEG_HEX_2;
            4'h3:    seg = SEG_HEX_3;
            4'h4:    seg = SEG_HEX_4;
            4'h5:    seg = SEG_HEX_5;
            4'h6:    seg = SEG_HEX_6;
            4'h7:    seg = SEG_HEX_7;
            4'h8:    seg = SEG_HEX_8;
            4'h9:    seg = SEG_HEX_9;
            4'hA:    seg = SEG_HEX_A;
            4'hB:    seg = SEG_HEX_B;
            4'hC:    seg = SEG_HEX_C;
            4'hD:    seg = SEG_HEX_D;
            4'hE:    seg = SEG_HEX_E;
            default: seg = SEG_HEX_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/opmux_hex_seg.sv
// Combinational 4-bit to 7-segment hex decoder, active-high, bit0=a .. bit6=g.
module opmux_hex_seg
    import opmux_pkg::*;
(
    input  logic [3:0]       i_digit,
    output logic [SEG_W-1:0] o_seg
);

    assign o_seg = hex_to_seg(i_digit);

endmodule

// File: rtl/operation_select_mux.sv
// Registered selector of PIPO / ALU / MOD5 / SSD results with one cycle latency.
// Define OPMUX_SSD_ECHO_EN to show result_out[3:0] as hex on ssd when sel != 11.
module operation_select_mux
    import opmux_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          sel,
    input  logic [3:0]          pipo_out,
    input  logic [RESULT_W-1:0] alu_out,
    input  logic [2:0]          mod5_out,
    input  logic [SEG_W-1:0]    ssd_out,
    output logic [RESULT_W-1:0] result_out,
    output logic [SEG_W-1:0]    ssd,
    output logic [1:0]          mode_out
);

    logic [RESULT_W-1:0] w_result_next;
    logic [SEG_W-1:0]    w_ssd_next;
    logic [SEG_W-1:0]    w_echo_seg;

    logic [RESULT_W-1:0] r_result;
    logic [SEG_W-1:0]    r_ssd;
    logic [1:0]          r_mode;

    // Only the selected source reaches the result; others are never read.
    always_comb begin
        w_result_next = '0;
        case (sel)
            MODE_PIPO: w_result_next = {1'b0, pipo_out};
            MODE_ALU:  w_result_next = alu_out;
            MODE_MOD5: w_result_next = {2'b00, mod5_out};
            MODE_SSD:  w_result_next = '0;
            default:   w_result_next = '0;
        endcase
    end

`ifdef OPMUX_SSD_ECHO_EN
    opmux_hex_seg u_hex_seg (
        .i_digit (w_result_next[3:0]),
        .o_seg   (w_echo_seg)
    );
`else
    assign w_echo_seg = SEG_BLANK;
`endif

    always_comb begin
        w_ssd_next = w_echo_seg;
        if (sel == MODE_SSD) begin
            w_ssd_next = ssd_out;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= '0;
            r_ssd    <= SEG_BLANK;
            r_mode   <= MODE_PIPO;
        end else begin
            r_result <= w_result_next;
            r_ssd    <= w_ssd_next;
            r_mode   <= sel;
        end
    end

    assign result_out = r_result;
    assign ssd        = r_ssd;
    assign mode_out   = r_mode;

endmodule

// File: tb/tb_operation_select_mux.sv
// Self-checking bench for operation_select_mux: directed cases then random
// traffic scored against a behavioural model through expected-value queues.
module tb_operation_select_mux;

    logic       clk;
    logic       reset;
    logic [1:0] sel;
    logic [3:0] pipo_out;
    logic [4:0] alu_out;
    logic [2:0] mod5_out;
    logic [6:0] ssd_out;
    logic [4:0] result_out;
    logic [6:0] ssd;
    logic [1:0] mode_out;

    int n_checks;
    int n_fail;

    logic [4:0] exp_res_q[$];
    logic [6:0] exp_ssd_q[$];
    logic [1:0] exp_mode_q[$];

    logic [6:0] hex_pat [16];

    operation_select_mux dut (
        .clk        (clk),
        .reset      (reset),
        .sel        (sel),
        .pipo_out   (pipo_out),
        .alu_out    (alu_out),
        .mod5_out   (mod5_out),
        .ssd_out    (ssd_out),
        .result_out (result_out),
        .ssd        (ssd),
        .mode_out   (mode_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_result(input int s, input int p, input int a, input int m);
        if (s == 0) return p;
        if (s == 1) return a;
        if (s == 2) return m;
        return 0;
    endfunction

    function automatic logic [6:0] model_ssd(input int s, input int res, input logic [6:0] seg_in);
        if (s == 3) return seg_in;
`ifdef OPMUX_SSD_ECHO_EN
        return hex_pat[res % 16];
`else
        if (res < 0) return 7'h7f;
        return 7'b0000000;
`endif
    endfunction

    // Drive one cycle of inputs, then score the registered outputs 1 ns after the edge.
    task automatic apply(input int s, input int p, input int a, input int m, input logic [6:0] seg_in);
        int res;
        sel      = 2'(s);
        pipo_out = 4'(p);
        alu_out  = 5'(a);
        mod5_out = 3'(m);
        ssd_out  = seg_in;
        res = model_result(s, p, a, m);
        exp_res_q.push_back(5'(res));
        exp_ssd_q.push_back(model_ssd(s, res, seg_in));
        exp_mode_q.push_back(2'(s));
        @(posedge clk);
        #1;
        check("result_out", {3'b0, result_out}, {3'b0, exp_res_q.pop_front()});
        check("ssd", {1'b0, ssd}, {1'b0, exp_ssd_q.pop_front()});
        check("mode_out", {6'b0, mode_out}, {6'b0, exp_mode_q.pop_front()});
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_result"}, {3'b0, result_out}, 8'd0);
        check({tag, "_ssd"}, {1'b0, ssd}, 8'd0);
        check({tag, "_mode"}, {6'b0, mode_out}, 8'd0);
    endtask

    initial begin
        hex_pat = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        sel      = 2'b01;
        pipo_out = 4'b1111;
        alu_out  = 5'b10101;
        mod5_out = 3'd0;
        ssd_out  = 7'b1111111;

        // Load a non-zero value, then show async reset clears it without an edge.
        @(posedge clk);
        #1;
        check("pre_reset_result", {3'b0, result_out}, 8'b00010101);
        #2;
        reset = 1'b1;
        #1;
        check_cleared("async_reset");
        @(posedge clk);
        #1;
        check_cleared("reset_hold");
        #3;
        reset = 1'b0;

        apply(0, 4'b1010, 0, 0, 7'b0);
        apply(1, 0, 5'b01010, 0, 7'b0);
        apply(1, 0, 5'b11110, 0, 7'b0);
        for (int i = 0; i < 6; i++) apply(2, 0, 0, i % 5, 7'b0);
        apply(2, 0, 0, 7, 7'b0);
        apply(3, 4'b1111, 5'b11111, 7, 7'b0000111);
        apply(1, 0, 5'b10011, 0, 7'b0);
        apply(3, 0, 5'b10011, 0, 7'b1011011);
        apply(0, 4'b0110, 0, 0, 7'b1011011);

        for (int i = 0; i < 200; i++) begin
            apply(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
                  7'($urandom_range(0, 127)));
        end

        // Reset in the middle of a cycle after live traffic.
        apply(1, 0, 5'b11011, 0, 7'b0);
        #2;
        reset = 1'b1;
        #1;
        check_cleared("mid_reset");
        @(posedge clk);
        #1;
        check_cleared("mid_reset_hold");
        #2;
        reset = 1'b0;
        apply(2, 0, 0, 3, 7'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
